// File: rtl/op_exec_pkg.sv
// op_exec_pkg
//   Shared types and helpers for the switch-driven operation executor.
//   op_t      : operation selector encoding (matches the 2-bit selector field)
//   state_t   : executor FSM states
//   SEG_BLANK : all segments off
//   hex_to_seg7 : 4-bit value -> active-high segments a..g on [6:0]
package op_exec_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SHOW
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
//   Combinational hex digit to 7-segment decoder (active-high).
//   Ports:
//     hex : input  [3:0] digit value
//     seg : output [6:0] segments a..g
module seg7_hex_decoder
    import op_exec_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg7(hex);
    end

endmodule

// File: rtl/op_exec_display.sv
// op_exec_display
//   Latches a switch-encoded command (A, B, selector) on start, executes it
//   (add/sub/compare in one cycle, multiply as a 3-step shift-add, LSB of B
//   first) and holds the result on the 7-segment digit and the LEDs.
//   Build option: OP_EXEC_SIGNED_EN treats operands as two's complement,
//   the decimal point then marks a negative result and the digit shows
//   the magnitude.
//   Ports:
//     clk_2   : system clock
//     reset   : synchronous, active-high
//     start   : one-cycle command strobe (ignored while busy)
//     val_a   : operand A
//     val_b   : operand B
//     seletor : 00 add, 01 sub, 10 mul, 11 compare
//     busy    : high while computing
//     done    : one-cycle pulse when the result is captured
//     result  : held result
//     SEG     : [6:0] segments a..g, [7] flag / decimal point
//     LED     : [5:0] result, [6] busy, [7] result valid
module op_exec_display
    import op_exec_pkg::*;
#(
    parameter int NBITS_OP  = 3,
    parameter int NBITS_RES = 6
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NBITS_OP-1:0]  val_a,
    input  logic [NBITS_OP-1:0]  val_b,
    input  logic [1:0]           seletor,
    output logic                 busy,
    output logic                 done,
    output logic [NBITS_RES-1:0] result,
    output logic [7:0]           SEG,
    output logic [7:0]           LED
);

    localparam int CW = $clog2(NBITS_OP);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS_OP - 1);

    state_t                state, state_nxt;
    op_t                   op_q;
    logic [NBITS_RES-1:0]  a_q, b_q, mcand, acc, acc_nxt, pp;
    logic [NBITS_OP-1:0]   mplier;
    logic [CW-1:0]         cnt;
    logic                  flag, valid;
    logic [NBITS_RES-1:0]  ext_a, ext_b, calc_res;
    logic                  calc_flag, lt, eq, accept, last_step;
    logic [3:0]            digit;
    logic [6:0]            seg_code;

    // Operand extension to result width
    always_comb begin
`ifdef OP_EXEC_SIGNED_EN
        ext_a = NBITS_RES'($signed(val_a));
        ext_b = NBITS_RES'($signed(val_b));
`else
        ext_a = NBITS_RES'(val_a);
        ext_b = NBITS_RES'(val_b);
`endif
    end

    assign accept    = start && (state != CALC);
    assign last_step = (op_q != OP_MUL) || (cnt == LAST_BIT);

    // FSM state register
    always_ff @(posedge clk_2) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and busy
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_step) state_nxt = SHOW;
            end
            SHOW: if (start) state_nxt = CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // Arithmetic
    always_comb begin
        pp = mplier[0] ? mcand : '0;
`ifdef OP_EXEC_SIGNED_EN
        // B's MSB carries negative weight in two's complement
        if (cnt == LAST_BIT) acc_nxt = acc - pp;
        else                 acc_nxt = acc + pp;
        lt = $signed(a_q) < $signed(b_q);
`else
        acc_nxt = acc + pp;
        lt = a_q < b_q;
`endif
        eq = (a_q == b_q);

        case (op_q)
            OP_ADD:  calc_res = a_q + b_q;
            OP_SUB:  calc_res = a_q - b_q;
            OP_MUL:  calc_res = acc_nxt;
            default: calc_res = lt ? NBITS_RES'(0) : (eq ? NBITS_RES'(1) : NBITS_RES'(2));
        endcase

`ifdef OP_EXEC_SIGNED_EN
        calc_flag = (op_q != OP_CMP) && calc_res[NBITS_RES-1];
`else
        case (op_q)
            OP_SUB:  calc_flag = lt;
            OP_MUL:  calc_flag = calc_res > NBITS_RES'(15);
            default: calc_flag = 1'b0;
        endcase
`endif
    end

    // Datapath: command latch, shift-add steps, result capture
    always_ff @(posedge clk_2) begin
        if (reset) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flag   <= 1'b0;
            valid  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q   <= op_t'(seletor);
                a_q    <= ext_a;
                b_q    <= ext_b;
                mcand  <= ext_a;
                mplier <= val_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last_step) begin
                    result <= calc_res;
                    flag   <= calc_flag;
                    valid  <= 1'b1;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Display
    always_comb begin
`ifdef OP_EXEC_SIGNED_EN
        digit = result[NBITS_RES-1] ? -result[3:0] : result[3:0];
`else
        digit = result[3:0];
`endif
    end

    seg7_hex_decoder u_dec (
        .hex (digit),
        .seg (seg_code)
    );

    assign SEG = valid ? {flag, seg_code} : SEG_BLANK;
    assign LED = {valid, busy, result[5:0]};

endmodule

// File: tb/tb_op_exec_display.sv
module tb_op_exec_display;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] sel;
        logic [5:0] res;
        logic [7:0] seg;
        logic [7:0] led;
        int         lat;
    } vec_t;

    logic       clk_2, reset, start, busy, done;
    logic [2:0] val_a, val_b;
    logic [1:0] seletor;
    logic [5:0] result;
    logic [7:0] SEG, LED;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t exp_q[$];

    op_exec_display #(.NBITS_OP(3), .NBITS_RES(6)) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .start   (start),
        .val_a   (val_a),
        .val_b   (val_b),
        .seletor (seletor),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .SEG     (SEG),
        .LED     (LED)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        bit   seen;
        bit   busy_ok;
        vec_t e;
        @(negedge clk_2);
        val_a = v.a; val_b = v.b; seletor = v.sel; start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk_2);
        start = 1'b0;
        // scramble inputs: the latched command must be used
        val_a = ~v.a; val_b = ~v.b; seletor = ~v.sel;
        cyc = 0; seen = 0; busy_ok = 1;
        while (!seen && cyc < 20) begin
            if (done) seen = 1;
            else begin
                if (!busy) busy_ok = 0;
                cyc++;
                @(negedge clk_2);
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_during_calc", 32'(busy_ok), 32'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            if (seen) begin
                chk("latency", 32'(cyc), 32'(e.lat));
                chk("result", 32'(result), 32'(e.res));
                chk("seg", 32'(SEG), 32'(e.seg));
                chk("led", 32'(LED), 32'(e.led));
                @(negedge clk_2);
                chk("done_one_cycle", 32'(done), 32'd0);
                @(negedge clk_2);
                chk("result_held", 32'(result), 32'(e.res));
                chk("seg_held", 32'(SEG), 32'(e.seg));
            end
        end
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
`ifdef OP_EXEC_SIGNED_EN
        vecs.push_back('{3'b100, 3'b011, 2'b10, 6'h34, 8'hB9, 8'hB4, 3});
        vecs.push_back('{3'b100, 3'b100, 2'b10, 6'h10, 8'h3F, 8'h90, 3});
        vecs.push_back('{3'b011, 3'b111, 2'b10, 6'h3D, 8'hCF, 8'hBD, 3});
        vecs.push_back('{3'b011, 3'b011, 2'b00, 6'h06, 8'h7D, 8'h86, 1});
        vecs.push_back('{3'b100, 3'b100, 2'b00, 6'h38, 8'hFF, 8'hB8, 1});
        vecs.push_back('{3'b100, 3'b011, 2'b01, 6'h39, 8'h87, 8'hB9, 1});
        vecs.push_back('{3'b011, 3'b100, 2'b01, 6'h07, 8'h07, 8'h87, 1});
        vecs.push_back('{3'b111, 3'b001, 2'b11, 6'h00, 8'h3F, 8'h80, 1});
        vecs.push_back('{3'b001, 3'b111, 2'b11, 6'h02, 8'h5B, 8'h82, 1});
        vecs.push_back('{3'b110, 3'b110, 2'b11, 6'h01, 8'h06, 8'h81, 1});
`else
        vecs.push_back('{3'd3, 3'd2, 2'b00, 6'h05, 8'h6D, 8'h85, 1});
        vecs.push_back('{3'd2, 3'd5, 2'b01, 6'h3D, 8'hDE, 8'hBD, 1});
        vecs.push_back('{3'd7, 3'd7, 2'b10, 6'h31, 8'h86, 8'hB1, 3});
        vecs.push_back('{3'd4, 3'd4, 2'b11, 6'h01, 8'h06, 8'h81, 1});
        vecs.push_back('{3'd5, 3'd1, 2'b11, 6'h02, 8'h5B, 8'h82, 1});
        vecs.push_back('{3'd1, 3'd6, 2'b11, 6'h00, 8'h3F, 8'h80, 1});
        vecs.push_back('{3'd7, 3'd7, 2'b00, 6'h0E, 8'h79, 8'h8E, 1});
        vecs.push_back('{3'd0, 3'd0, 2'b00, 6'h00, 8'h3F, 8'h80, 1});
        vecs.push_back('{3'd7, 3'd0, 2'b01, 6'h07, 8'h07, 8'h87, 1});
        vecs.push_back('{3'd0, 3'd7, 2'b01, 6'h39, 8'hEF, 8'hB9, 1});
        vecs.push_back('{3'd3, 3'd5, 2'b10, 6'h0F, 8'h71, 8'h8F, 3});
        vecs.push_back('{3'd4, 3'd4, 2'b10, 6'h10, 8'hBF, 8'h90, 3});
        vecs.push_back('{3'd0, 3'd7, 2'b10, 6'h00, 8'h3F, 8'h80, 3});
        vecs.push_back('{3'd5, 3'd6, 2'b10, 6'h1E, 8'hF9, 8'h9E, 3});
`endif

        reset = 1'b1; start = 1'b0; val_a = '0; val_b = '0; seletor = '0;
        repeat (3) @(negedge clk_2);
        reset = 1'b0;
        @(negedge clk_2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_seg", 32'(SEG), 32'h00);
        chk("rst_led", 32'(LED), 32'h00);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start while busy is ignored: 3*3 mul (9 in both modes)
        @(negedge clk_2);
        val_a = 3'd3; val_b = 3'd3; seletor = 2'b10; start = 1'b1;
        exp_q.push_back('{3'd3, 3'd3, 2'b10, 6'h09, 8'h6F, 8'h89, 3});
        @(negedge clk_2);
        val_a = 3'd1; val_b = 3'd1; seletor = 2'b00; // start still high in CALC
        @(negedge clk_2);
        start = 1'b0;
        begin
            int   cyc;
            bit   seen;
            vec_t e;
            cyc = 1; seen = 0;
            while (!seen && cyc < 20) begin
                if (done) seen = 1;
                else begin cyc++; @(negedge clk_2); end
            end
            chk("busy_start_done_seen", 32'(seen), 32'd1);
            e = exp_q.pop_front();
            chk("busy_start_latency", 32'(cyc), 32'(e.lat));
            chk("busy_start_result", 32'(result), 32'(e.res));
            chk("busy_start_led", 32'(LED), 32'(e.led));
            @(negedge clk_2);
            chk("busy_start_no_restart", 32'(busy), 32'd0);
        end

        // Reset in the 2nd cycle of a multiply
        @(negedge clk_2);
        val_a = 3'd3; val_b = 3'd3; seletor = 2'b10; start = 1'b1;
        @(negedge clk_2);
        start = 1'b0;
        @(negedge clk_2);
        chk("mid_mul_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk_2);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_seg", 32'(SEG), 32'h00);
        chk("mid_rst_led", 32'(LED), 32'h00);
        begin
            bit any_done;
            any_done = 0;
            repeat (5) begin
                @(negedge clk_2);
                if (done) any_done = 1;
            end
            chk("mid_rst_no_done", 32'(any_done), 32'd0);
            chk("mid_rst_seg_blank", 32'(SEG), 32'h00);
        end

        // start and reset together: reset wins
        @(negedge clk_2);
        val_a = 3'd1; val_b = 3'd1; seletor = 2'b00; start = 1'b1; reset = 1'b1;
        @(negedge clk_2);
        start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk_2);
        chk("rst_start_done", 32'(done), 32'd0);
        chk("rst_start_led", 32'(LED), 32'h00);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/op_exec_display.md
Name: op_exec_display

Overview:
- Consumes the switch-encoded command: 3-bit operand A, 3-bit operand B and a 2-bit operation selector.
- Executes the command sequentially: single-cycle for add/subtract/compare, shift-add over 3 cycles for multiply.
- Presents the result on the 7-segment digit and the LEDs, and holds it there until the next command.
- Sits inside top between the SWI field extraction and the SEG/LED outputs.

Parameters:
- NBITS_OP, 3, operand width (A and B).
- NBITS_RES, 6, result register width (holds 7*7=49).

Ports:
- clk_2  input  1  system clock (divided board clock).
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command strobe (debounced/edge-detected externally).
- val_a  input  NBITS_OP  operand A.
- val_b  input  NBITS_OP  operand B.
- seletor  input  2  operation: 00 add, 01 sub (A-B), 10 mul, 11 compare.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result is captured.
- result  output  NBITS_RES  held result.
- SEG  output  8  segments a..g on [6:0], active-high; [7] = flag (decimal point).
- LED  output  8  [5:0] = result, [6] = busy, [7] = result valid.

Behaviour:
- FSM states: IDLE, CALC, SHOW.
  - IDLE -> CALC on start.
  - CALC -> SHOW when the op completes.
  - SHOW -> CALC on start.
  - Otherwise hold the current state.
- Operands and selector are latched on the accepted start edge. Input changes during CALC/SHOW are ignored until the next start.
- start while busy (CALC) is ignored. No queuing.
- Latency from the start cycle to the done pulse:
  - add/sub/compare: done 1 cycle after start, i.e. 1 cycle in CALC.
  - mul: done 3 cycles after start, i.e. 3 cycles in CALC, one shift-add per bit of B (LSB first).
  - result, SEG and LED update in the same cycle done is asserted.
- Arithmetic:
  - add: zero-extended, 0..14.
  - sub: 4-bit two's complement A-B, sign-extended into result; flag = 1 when A<B.
  - mul: unsigned, 0..49; flag = 1 when result>15.
  - compare: result = 0 for A<B, 1 for A==B, 2 for A>B; flag = 0.
- SEG digit encodes result[3:0] as hex using standard active-high codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- Reset (applied in any state, including mid-multiply):
  - state = IDLE; busy=0, done=0, result=0, flag=0, LED=0x00.
  - SEG = 0x00 (blank) until the first result.
- In IDLE the display stays blank. From SHOW onward it holds the last result until the next done.
- start and reset in the same cycle: reset wins.
- busy = (state==CALC). LED[7] = 1 from the first done until reset.

Optional Feature:
- Macro: OP_EXEC_SIGNED_EN.
- Defined:
  - Operands are 3-bit two's complement (-4..3).
  - add/sub results are sign-extended; flag = result negative.
  - mul uses a signed shift-add (range -12..16).
  - compare is signed.
  - SEG shows the magnitude of result[3:0]; the decimal point marks negative.
- Undefined: the unsigned behaviour above.

Decomposition:
- Package op_exec_pkg:
  - enum op_t {OP_ADD, OP_SUB, OP_MUL, OP_CMP}.
  - enum state_t {IDLE, CALC, SHOW}.
  - constant SEG_BLANK=8'h00.
  - function or constant table for the hex-to-7-segment codes.
- One sub-module: seg7_hex_decoder (combinational, 4-bit in -> 7 segments out). Reused by other top-level labs.

Test Plan:
- Reset, then A=3, B=2, seletor=00, start -> done 1 cycle later; result=5, SEG=0x6D, LED=0x85.
- A=2, B=5, seletor=01 -> result[3:0]=0xD (-3), SEG=0x5E|0x80=0xDE.
- A=7, B=7, seletor=10 -> busy for 3 cycles, done on cycle 3; result=49 (0x31), SEG=0x06|0x80=0x86, LED=0xB1.
- A=4, B=4, seletor=11 -> result=1. Then A=5, B=1 -> result=2, SEG=0x5B.
- Start a mul, pulse start again while busy -> second start ignored, product unchanged. Start a mul, assert reset in its 2nd cycle -> IDLE, all outputs 0, no done pulse.
- With OP_EXEC_SIGNED_EN: A=-4 (3'b100), B=3, seletor=10 -> result=-12, SEG shows C with DP (0xB9).
